// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands enter in parallel, are processed
// LSB-first through one full-adder slice with a registered carry, and the
// reassembled result is handed downstream over a valid/ready handshake.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic             carry_out_r;
    logic             overflow_r;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic             accept;
    logic             handoff;

    // Full-adder bit slice on the current LSBs and the registered carry.
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;

    assign result    = res_sh;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the MSB, DONE -> IDLE on handoff.
    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (handoff)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per cycle through the slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            carry       <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            cnt         <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and preload the carry with 1.
            a_sh  <= op_a;
            b_sh  <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
            carry  <= carry_nxt;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                // carry still holds the carry into the MSB at this point.
                carry_out_r <= carry_nxt;
                overflow_r  <= carry ^ carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with an arithmetic reference model and a
// per-cycle compare process on the result bundle.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [W+1:0] exp_bundle;
    logic         exp_live = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {overflow, carry_out, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        int unsigned  ai = 32'(a);
        int unsigned  bi = 32'(b);
        int unsigned  full;
        logic [W-1:0] r;
        logic         cy;
        logic         v;
        if (!s) begin
            full = ai + bi;
            cy   = (full >> W) != 0;
            r    = W'(full);
            v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            full = ai - bi;
            cy   = (ai >= bi);
            r    = W'(full);
            v    = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {v, cy, r};
    endfunction

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid && exp_live) begin
            check("cmp_result",   32'(result),    32'(exp_bundle[W-1:0]));
            check("cmp_carry",    32'(carry_out), 32'(exp_bundle[W]));
            check("cmp_overflow", 32'(overflow),  32'(exp_bundle[W+1]));
        end
    end

    // Present operands and wait (bounded) for acceptance; leaves in_valid low afterwards.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int i;
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        for (i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        exp_bundle = model(a, b, s);
        exp_live   = 1'b1;
    endtask

    // Count cycles after acceptance until out_valid, optionally scrambling inputs meanwhile.
    task automatic wait_result(input bit scramble, output int n);
        n = 0;
        while (n < 3 * W) begin
            if (scramble) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                sub  = 1'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
    endtask

    // Full operation with out_ready high, checking latency, literal result and return to IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] er, input logic ec, input logic ev,
                         input bit scramble, input string tag);
        int n;
        out_ready = 1'b1;
        start_op(a, b, s);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        wait_result(scramble, n);
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"}, 32'(carry_out), 32'(ec));
        check({tag, "_overflow"}, 32'(overflow), 32'(ev));
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        exp_live = 1'b0;
    endtask

    initial begin
        int n;
        int stray;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_carry",     32'(carry_out), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, "add_05_03");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "add_ff_01");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "add_7f_01");
        do_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_03_05");
        do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_80_01");
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, "scramble");

        // Backpressure: result held, a stray in_valid must not be accepted or queued.
        out_ready = 1'b0;
        start_op(8'h10, 8'h20, 1'b0);
        wait_result(1'b0, n);
        check("bp_latency", 32'(n), 32'(W));
        op_a     = 8'hAA;
        op_b     = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result",    32'(result),    32'h30);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        exp_live = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (busy || out_valid) stray++;
        end
        check("bp_not_queued", 32'(stray), 32'd0);

        // Asynchronous reset mid-RUN.
        start_op(8'h11, 8'h22, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_result",    32'(result),    32'd0);
        check("mid_rst_carry",     32'(carry_out), 32'd0);
        check("mid_rst_overflow",  32'(overflow),  32'd0);
        exp_live = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check("mid_rst_no_valid", 32'(stray), 32'd0);

        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Bit-serial adder/subtractor sequencer for the calculator datapath.
- Accepts two WIDTH-bit operands and an add/sub select over a valid/ready handshake.
- Feeds the operands LSB-first, one bit per clock, through a single full-adder bit slice, with a registered carry between bits.
- Reassembles the sum bits into a parallel result, then presents the result, carry and signed-overflow flag downstream over a second valid/ready handshake.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A (two's complement or unsigned)
op_b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result bundle valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference, modulo 2^WIDTH
carry_out  output  1  carry out of MSB; for sub, 1 = no borrow
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, result = 0, carry_out = 0, overflow = 0. All internal shift registers, carry flop and bit counter are cleared.
- IDLE state:
  - in_ready = 1.
  - On a rising edge with in_valid && in_ready: latch A_sh = op_a and B_sh = sub ? ~op_b : op_b; set carry = sub; set bit counter = 0; go to RUN.
  - in_ready drops to 0 the cycle after acceptance.
- RUN state (exactly WIDTH cycles):
  - Combinational slice each cycle: s = A_sh[0] ^ B_sh[0] ^ carry; c = majority(A_sh[0], B_sh[0], carry). The FullAdder cell may be instantiated for this.
  - On each edge: shift A_sh and B_sh right by one; shift the result register right with s inserted at bit WIDTH-1; carry <= c; counter++.
  - On the edge processing bit WIDTH-1: capture carry_in_msb = the carry before the update; carry_out = c; overflow = carry_in_msb ^ c; go to DONE.
- DONE state:
  - out_valid = 1; result, carry_out and overflow are held stable.
  - On an edge with out_valid && out_ready: out_valid <= 0, go to IDLE, in_ready <= 1.
  - in_ready stays 0 throughout DONE; there is no overlap of a new operation with a pending result.
- Latency: operands accepted at edge t; out_valid first seen high after edge t+WIDTH. Throughput is at best one operation per WIDTH+2 cycles with out_ready held high.
- Operands are sampled only at acceptance. Changes on op_a, op_b or sub during RUN/DONE have no effect.
- in_valid during RUN/DONE is ignored and not queued.
- out_ready asserted while out_valid = 0 has no effect.
- Wrap-around: result is modulo 2^WIDTH; the carry out of the MSB is reported only via carry_out.
- Reset asserted mid-RUN or in DONE aborts the operation immediately and returns all outputs to reset values. No partial result is ever presented.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, add 0x05 + 0x03, out_ready=1 -> out_valid rises 8 cycles after acceptance; result=0x08, carry_out=0, overflow=0; back in IDLE with in_ready=1 one cycle later.
- Add 0xFF + 0x01 -> result=0x00, carry_out=1, overflow=0. Then add 0x7F + 0x01 -> result=0x80, carry_out=0, overflow=1.
- Sub 0x03 - 0x05 -> result=0xFE, carry_out=0 (borrow), overflow=0. Then sub 0x80 - 0x01 -> result=0x7F, carry_out=1, overflow=1.
- Backpressure: after 0x10+0x20 completes, hold out_ready=0 for 5 cycles -> out_valid stays 1, result stays 0x30, in_ready stays 0. A second in_valid pulse in this window is not accepted. Raising out_ready -> one handshake, then IDLE.
- Operand change mid-RUN: accept 0x12+0x34, change op_a/op_b/sub every cycle during RUN -> result=0x46, carry_out=0, overflow=0.
- Reset mid-RUN: pulse rst_n low asynchronously (between edges) 3 cycles into an operation -> outputs return to reset values immediately and no out_valid appears. A subsequent 0x01+0x01 yields 0x02 after 8 cycles.
